memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's ALU result, store data and control bundle.
- Performs load/store accesses on a req/gnt/rvalid data-memory bus, with byte/half/word formatting and alignment checks.
- Stalls the pipeline while an access is outstanding, then registers results into the MEM/WB pipeline register for writeback.

---
 rtl/memory_stage_pkg.sv | 36 +++
 rtl/memory_stage_formatter.sv | 61 ++++++
 rtl/memory_stage.sv | 203 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory stage.
// Contents:
//   mem_state_t   - bus access FSM states
//   F3_*          - funct3 encodings for loads and stores
//   control_type  - control bundle carried from execute into MEM/WB
//   word_align    - clears the byte offset of an address
package memory_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [2:0] funct3;
    } control_type;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/memory_stage_formatter.sv
// Combinational byte/half/word formatting for the memory stage.
// Ports:
//   funct3      in   access size and signedness
//   offset      in   byte offset within the word (address bits [1:0])
//   store_data  in   raw store data (rs2)
//   rdata       in   raw word read from the bus
//   be          out  byte enables for the access
//   wdata       out  lane-replicated store data
//   misaligned  out  access does not fit its natural alignment
//   load_data   out  extracted and extended load value
module load_store_formatter
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Size is carried in funct3[1:0]; replication lets the bus pick any lane.
    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << offset;
                wdata      = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            default: begin
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = |offset;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then extend.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_data = {24'h000000, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on a req/gnt/rvalid bus,
// stalls upstream while an access is outstanding, and registers the
// result into the MEM/WB pipeline register.
// Ports:
//   clk, rst                      clock, async active-high reset
//   valid_in, control_in,         instruction from execute (held while
//   alu_data, memory_data, rd_in  stall_out is high)
//   stall_out                     hold request to upstream
//   dmem_*                        data memory bus
//   valid_out, control_out,       MEM/WB register contents
//   alu_data_out, mem_data_out,
//   rd_out, misaligned, bus_error
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  control_type control_in,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    input  logic [4:0]  rd_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        valid_out,
    output control_type control_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] mem_data_out,
    output logic [4:0]  rd_out,
    output logic        misaligned,
    output logic        bus_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_t    state;
    mem_state_t    next_state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          is_mem;
    logic          is_load;
    logic          fault;
    logic          issue;
    logic          fmt_misaligned;
    logic [31:0]   load_data;
    logic          timeout_hit;

    logic          req_c;
    logic          stall_c;
    logic          complete;
    logic          load_done;
    logic          timed_out;

    load_store_formatter u_formatter (
        .funct3     (control_in.funct3),
        .offset     (alu_data[1:0]),
        .store_data (memory_data),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .misaligned (fmt_misaligned),
        .load_data  (load_data)
    );

    // A set mem_read wins over mem_write, so such an op is a load.
    assign is_mem      = valid_in && (control_in.mem_read || control_in.mem_write);
    assign is_load     = control_in.mem_read;
    assign fault       = is_mem && fmt_misaligned;
    assign issue       = is_mem && !fmt_misaligned;
    assign timeout_hit = (count >= TO_LAST);

    assign dmem_we   = !control_in.mem_read && control_in.mem_write;
    assign dmem_addr = word_align(alu_data);

    // Reset gates the combinational outputs so an in-flight request drops
    // the instant rst rises, even though the inputs are still presented.
    assign dmem_req  = req_c && !rst;
    assign stall_out = stall_c && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= count_next;
        end
    end

    // Next-state logic. A grant always takes priority over the timeout on
    // the same cycle because the bus has already accepted the request, and
    // rvalid likewise beats the timeout in WAIT_RVALID.
    always_comb begin
        next_state = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        complete   = 1'b0;
        load_done  = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    req_c = 1'b1;
                    if (dmem_gnt) begin
                        if (is_load) begin
                            next_state = WAIT_RVALID;
                            stall_c    = 1'b1;
                        end else begin
                            complete = 1'b1;
                        end
                    end else begin
                        next_state = WAIT_GNT;
                        stall_c    = 1'b1;
                    end
                end else if (valid_in) begin
                    complete = 1'b1;
                end
            end
            WAIT_GNT: begin
                req_c = 1'b1;
                if (dmem_gnt) begin
                    if (is_load) begin
                        next_state = WAIT_RVALID;
                        stall_c    = 1'b1;
                    end else begin
                        next_state = IDLE;
                        complete   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                    timed_out  = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            WAIT_RVALID: begin
                if (dmem_rvalid) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                    load_done  = 1'b1;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                    timed_out  = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // The counter spans both wait states so gnt and rvalid share one budget.
        if (complete) begin
            count_next = '0;
        end else if (state != IDLE) begin
            count_next = count + 1'b1;
        end else begin
            count_next = '0;
        end
    end

    // MEM/WB register. Faults suppress the register write; fault flags are
    // cleared on bubbles so they never linger next to valid_out=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            control_out  <= '0;
            alu_data_out <= '0;
            mem_data_out <= '0;
            rd_out       <= '0;
            misaligned   <= 1'b0;
            bus_error    <= 1'b0;
        end else if (complete) begin
            valid_out             <= 1'b1;
            control_out           <= control_in;
            control_out.reg_write <= control_in.reg_write && !fault && !timed_out;
            alu_data_out          <= alu_data;
            mem_data_out          <= load_done ? load_data : 32'h0;
            rd_out                <= rd_in;
            misaligned            <= fault;
            bus_error             <= timed_out;
        end else begin
            valid_out  <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (TIMEOUT_CYCLES = 4).
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_in;
    control_type control_in;
    logic [31:0] alu_data;
    logic [31:0] memory_data;
    logic [4:0]  rd_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        valid_out;
    control_type control_out;
    logic [31:0] alu_data_out;
    logic [31:0] mem_data_out;
    logic [4:0]  rd_out;
    logic        misaligned;
    logic        bus_error;

    int testsRun;
    int testsFailed;

    memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .control_in   (control_in),
        .alu_data     (alu_data),
        .memory_data  (memory_data),
        .rd_in        (rd_in),
        .stall_out    (stall_out),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_be      (dmem_be),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .valid_out    (valid_out),
        .control_out  (control_out),
        .alu_data_out (alu_data_out),
        .mem_data_out (mem_data_out),
        .rd_out       (rd_out),
        .misaligned   (misaligned),
        .bus_error    (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    // Loads set reg_write/mem_to_reg; stores clear reg_write.
    task automatic applyStimulus(input logic v, input logic rd_en, input logic wr_en,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [4:0] rd);
        valid_in              = v;
        control_in.mem_read   = rd_en;
        control_in.mem_write  = wr_en;
        control_in.reg_write  = !wr_en || rd_en;
        control_in.mem_to_reg = rd_en;
        control_in.funct3     = f3;
        alu_data              = addr;
        memory_data           = data;
        rd_in                 = rd;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b1, 1'b0, f3, addr, 32'h0, 5'd7);
        dmem_gnt = 1'b1;
        #2;
        checkOutput({tag, " req"}, {31'h0, dmem_req}, 32'h1);
        checkOutput({tag, " stall"}, {31'h0, stall_out}, 32'h1);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        #2;
        checkOutput({tag, " req in wait"}, {31'h0, dmem_req}, 32'h0);
        checkOutput({tag, " stall at rvalid"}, {31'h0, stall_out}, 32'h0);
        tick();
        checkOutput({tag, " valid_out"}, {31'h0, valid_out}, 32'h1);
        checkOutput({tag, " data"}, mem_data_out, expected);
        idleInputs();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        dmem_rdata  = 32'h0;
        idleInputs();

        // Reset: a pending load must not reach the bus while rst is high.
        applyStimulus(1'b1, 1'b1, 1'b0, F3_LW, 32'h40, 32'h0, 5'd1);
        tick();
        tick();
        checkOutput("reset req", {31'h0, dmem_req}, 32'h0);
        checkOutput("reset stall", {31'h0, stall_out}, 32'h0);
        checkOutput("reset valid_out", {31'h0, valid_out}, 32'h0);
        checkOutput("reset alu_data_out", alu_data_out, 32'h0);
        idleInputs();
        rst = 1'b0;
        tick();

        // Non-memory instruction
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5);
        #2;
        checkOutput("alu stall", {31'h0, stall_out}, 32'h0);
        checkOutput("alu req", {31'h0, dmem_req}, 32'h0);
        tick();
        checkOutput("alu valid_out", {31'h0, valid_out}, 32'h1);
        checkOutput("alu alu_data_out", alu_data_out, 32'h1234);
        checkOutput("alu rd_out", {27'h0, rd_out}, 32'd5);
        checkOutput("alu reg_write", {31'h0, control_out.reg_write}, 32'h1);
        checkOutput("alu mem_data_out", mem_data_out, 32'h0);
        idleInputs();
        tick();
        checkOutput("bubble valid_out", {31'h0, valid_out}, 32'h0);

        // SB with grant withheld for three cycles
        applyStimulus(1'b1, 1'b0, 1'b1, F3_SB, 32'h103, 32'h000000AB, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput("sb req", {31'h0, dmem_req}, 32'h1);
            checkOutput("sb stall", {31'h0, stall_out}, 32'h1);
            checkOutput("sb be", {28'h0, dmem_be}, 32'h8);
            checkOutput("sb wdata", dmem_wdata, 32'hABABABAB);
            checkOutput("sb addr", dmem_addr, 32'h100);
            checkOutput("sb we", {31'h0, dmem_we}, 32'h1);
            tick();
            checkOutput("sb valid_out while stalled", {31'h0, valid_out}, 32'h0);
        end
        dmem_gnt = 1'b1;
        #2;
        checkOutput("sb req at gnt", {31'h0, dmem_req}, 32'h1);
        checkOutput("sb stall at gnt", {31'h0, stall_out}, 32'h0);
        tick();
        checkOutput("sb valid_out", {31'h0, valid_out}, 32'h1);
        checkOutput("sb misaligned", {31'h0, misaligned}, 32'h0);
        checkOutput("sb reg_write", {31'h0, control_out.reg_write}, 32'h0);
        idleInputs();
        tick();

        // SH lane placement in the upper half
        applyStimulus(1'b1, 1'b0, 1'b1, F3_SH, 32'h102, 32'h00001234, 5'd0);
        dmem_gnt = 1'b1;
        #2;
        checkOutput("sh be", {28'h0, dmem_be}, 32'hC);
        checkOutput("sh wdata", dmem_wdata, 32'h12341234);
        tick();
        checkOutput("sh valid_out", {31'h0, valid_out}, 32'h1);
        idleInputs();
        tick();

        // Loads with extension
        doLoad("lb", F3_LB, 32'h102, 32'h00800000, 32'hFFFFFF80);
        doLoad("lbu", F3_LBU, 32'h102, 32'h00800000, 32'h00000080);
        doLoad("lh", F3_LH, 32'h102, 32'hBEEF0000, 32'hFFFFBEEF);
        doLoad("lhu", F3_LHU, 32'h102, 32'hBEEF0000, 32'h0000BEEF);
        doLoad("lw", F3_LW, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D);

        // Misaligned LW
        applyStimulus(1'b1, 1'b1, 1'b0, F3_LW, 32'h201, 32'h0, 5'd3);
        dmem_gnt = 1'b1;
        #2;
        checkOutput("mis req", {31'h0, dmem_req}, 32'h0);
        checkOutput("mis stall", {31'h0, stall_out}, 32'h0);
        tick();
        checkOutput("mis valid_out", {31'h0, valid_out}, 32'h1);
        checkOutput("mis flag", {31'h0, misaligned}, 32'h1);
        checkOutput("mis reg_write", {31'h0, control_out.reg_write}, 32'h0);
        idleInputs();
        tick();

        // Timeout: granted load, rvalid never arrives within 4 waiting cycles
        applyStimulus(1'b1, 1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 5'd4);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput("to stall", {31'h0, stall_out}, 32'h1);
            tick();
            checkOutput("to valid_out while waiting", {31'h0, valid_out}, 32'h0);
        end
        #2;
        checkOutput("to stall at expiry", {31'h0, stall_out}, 32'h0);
        tick();
        checkOutput("to valid_out", {31'h0, valid_out}, 32'h1);
        checkOutput("to bus_error", {31'h0, bus_error}, 32'h1);
        checkOutput("to reg_write", {31'h0, control_out.reg_write}, 32'h0);
        idleInputs();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h11111111;
        tick();
        checkOutput("late rvalid valid_out", {31'h0, valid_out}, 32'h0);
        dmem_rvalid = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd9);
        tick();
        checkOutput("after to valid_out", {31'h0, valid_out}, 32'h1);
        checkOutput("after to alu_data_out", alu_data_out, 32'h55);
        checkOutput("after to bus_error", {31'h0, bus_error}, 32'h0);

        // Reset asserted while waiting for rvalid
        applyStimulus(1'b1, 1'b1, 1'b0, F3_LW, 32'h400, 32'h0, 5'd6);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #2;
        checkOutput("rst pre stall", {31'h0, stall_out}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rst async stall", {31'h0, stall_out}, 32'h0);
        checkOutput("rst async req", {31'h0, dmem_req}, 32'h0);
        checkOutput("rst async alu_data_out", alu_data_out, 32'h0);
        checkOutput("rst async rd_out", {27'h0, rd_out}, 32'h0);
        tick();
        rst = 1'b0;
        idleInputs();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h22222222;
        tick();
        checkOutput("rst late rvalid valid_out", {31'h0, valid_out}, 32'h0);
        checkOutput("rst late rvalid data", mem_data_out, 32'h0);
        dmem_rvalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
